// File: rtl/cpu_pkg.sv
// Shared opcode, state, ALU and PC-source encodings for the multicycle CPU.
// CU_JUMP_LINK_EN enables decoding of jal and jr; otherwise both fall to nop.
package cpu_pkg;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JR   = 6'b111001;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   // sHALT shares the sIF code; the separate halt flag tells them apart
   localparam logic [2:0] S_IF     = 3'b000;
   localparam logic [2:0] S_ID     = 3'b001;
   localparam logic [2:0] S_EXE_LS = 3'b010;
   localparam logic [2:0] S_MEM    = 3'b011;
   localparam logic [2:0] S_WB_LD  = 3'b100;
   localparam logic [2:0] S_EXE_BR = 3'b101;
   localparam logic [2:0] S_EXE_AL = 3'b110;
   localparam logic [2:0] S_WB_AL  = 3'b111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JR  = 2'b10;
   localparam logic [1:0] PCSRC_J   = 2'b11;

   localparam logic [1:0] WRSEL_R31 = 2'b00;
   localparam logic [1:0] WRSEL_RT  = 2'b01;
   localparam logic [1:0] WRSEL_RD  = 2'b10;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_AL,
      CLS_BR,
      CLS_LS,
      CLS_JMP,
      CLS_HALT
   } op_class_e;

   function automatic op_class_e classify(input logic [5:0] op);
      op_class_e cls;
      cls = CLS_NOP;
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
         OP_ORI, OP_SLL, OP_SLT:             cls = CLS_AL;
         OP_BEQ:                             cls = CLS_BR;
         OP_SW, OP_LW:                       cls = CLS_LS;
         OP_J:                               cls = CLS_JMP;
`ifdef CU_JUMP_LINK_EN
         OP_JR, OP_JAL:                      cls = CLS_JMP;
`endif
         OP_HALT:                            cls = CLS_HALT;
         default:                            cls = CLS_NOP;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Output decode: maps registered state, halt flag, opcode and zero to control lines.
// CU_JUMP_LINK_EN selects r31 as destination for jal.
module cu_decode
   import cpu_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic           rst,
   input  logic           halt,
   input  logic [2:0]     st,
   input  logic [OPW-1:0] op,
   input  logic           zero,
   output logic           pc_wre,
   output logic           ir_wre,
   output logic           reg_wre,
   output logic [1:0]     wr_reg_sel,
   output logic           alu_src_a,
   output logic           alu_src_b,
   output logic [2:0]     alu_op,
   output logic           ext_sel,
   output logic           data_mem_wr,
   output logic           db_data_src,
   output logic [1:0]     pc_src
);

   logic [5:0] op6;
   op_class_e  cls;

   assign op6 = 6'(op);
   assign cls = classify(op6);

   always_comb begin
      pc_wre      = 1'b0;
      ir_wre      = 1'b0;
      reg_wre     = 1'b0;
      wr_reg_sel  = '0;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      alu_op      = ALU_ADD;
      ext_sel     = 1'b0;
      data_mem_wr = 1'b0;
      db_data_src = 1'b0;
      pc_src      = PCSRC_SEQ;
      // Reset and halt both silence every output, including op-derived ones
      if (!rst && !halt) begin
         ir_wre = (st == S_IF);
         case (op6)
            OP_ADD:  begin alu_op = ALU_ADD; wr_reg_sel = WRSEL_RD; end
            OP_SUB:  begin alu_op = ALU_SUB; wr_reg_sel = WRSEL_RD; end
            OP_OR:   begin alu_op = ALU_OR;  wr_reg_sel = WRSEL_RD; end
            OP_AND:  begin alu_op = ALU_AND; wr_reg_sel = WRSEL_RD; end
            OP_SLT:  begin alu_op = ALU_SLT; wr_reg_sel = WRSEL_RD; end
            OP_SLL:  begin alu_op = ALU_SLL; alu_src_a = 1'b1; wr_reg_sel = WRSEL_RD; end
            OP_ADDI: begin alu_op = ALU_ADD; alu_src_b = 1'b1; ext_sel = 1'b1; wr_reg_sel = WRSEL_RT; end
            OP_ORI:  begin alu_op = ALU_OR;  alu_src_b = 1'b1; wr_reg_sel = WRSEL_RT; end
            OP_SW:   begin alu_op = ALU_ADD; alu_src_b = 1'b1; ext_sel = 1'b1; end
            OP_LW:   begin
               alu_op = ALU_ADD; alu_src_b = 1'b1; ext_sel = 1'b1;
               wr_reg_sel = WRSEL_RT; db_data_src = 1'b1;
            end
            OP_BEQ:  begin alu_op = ALU_SUB; ext_sel = 1'b1; end
`ifdef CU_JUMP_LINK_EN
            OP_JAL:  wr_reg_sel = WRSEL_R31;
`endif
            default: ;
         endcase
         case (st)
            S_ID: begin
               if (cls == CLS_JMP) begin
                  pc_wre  = 1'b1;
                  pc_src  = (op6 == OP_JR) ? PCSRC_JR : PCSRC_J;
                  reg_wre = (op6 == OP_JAL);
               end else if (cls == CLS_NOP) begin
                  pc_wre = 1'b1;
               end
            end
            S_EXE_BR: begin
               pc_wre = 1'b1;
               pc_src = zero ? PCSRC_BR : PCSRC_SEQ;
            end
            S_WB_AL, S_WB_LD: begin
               pc_wre  = 1'b1;
               reg_wre = 1'b1;
            end
            S_MEM: begin
               pc_wre      = (op6 == OP_SW);
               data_mem_wr = (op6 == OP_SW);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle CPU control unit: state register, halt flag and next-state logic.
// CU_JUMP_LINK_EN enables jal/jr sequencing (see cpu_pkg::classify).
module control_unit
   import cpu_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 3
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [OPW-1:0] op,
   input  logic           zero,
   output logic           PCWre,
   output logic           IRWre,
   output logic           RegWre,
   output logic [1:0]     WrRegSel,
   output logic           ALUSrcA,
   output logic           ALUSrcB,
   output logic [2:0]     ALUOp,
   output logic           ExtSel,
   output logic           DataMemWr,
   output logic           DBDataSrc,
   output logic [1:0]     PCSrc,
   output logic [STW-1:0] state
);

   logic [2:0] state_q, state_d;
   logic       halt_q, halt_d;
   op_class_e  cls;

   assign cls = classify(6'(op));

   always_comb begin
      state_d = state_q;
      halt_d  = halt_q;
      if (!halt_q) begin
         case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
               case (cls)
                  CLS_AL:   state_d = S_EXE_AL;
                  CLS_BR:   state_d = S_EXE_BR;
                  CLS_LS:   state_d = S_EXE_LS;
                  CLS_HALT: begin state_d = S_IF; halt_d = 1'b1; end
                  default:  state_d = S_IF;
               endcase
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = (6'(op) == OP_LW) ? S_WB_LD : S_IF;
            default:  state_d = S_IF;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IF;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         halt_q  <= halt_d;
      end
   end

   assign state = RST ? '0 : STW'(state_q);

   cu_decode #(.OPW(OPW)) u_decode (
      .rst         (RST),
      .halt        (halt_q),
      .st          (state_q),
      .op          (op),
      .zero        (zero),
      .pc_wre      (PCWre),
      .ir_wre      (IRWre),
      .reg_wre     (RegWre),
      .wr_reg_sel  (WrRegSel),
      .alu_src_a   (ALUSrcA),
      .alu_src_b   (ALUSrcB),
      .alu_op      (ALUOp),
      .ext_sel     (ExtSel),
      .data_mem_wr (DataMemWr),
      .db_data_src (DBDataSrc),
      .pc_src      (PCSrc)
   );

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; expectations follow CU_JUMP_LINK_EN.
module tb_control_unit;

   logic       CLK = 1'b0;
   logic       RST;
   logic [5:0] op;
   logic       zero;
   logic       PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, ExtSel, DataMemWr, DBDataSrc;
   logic [1:0] WrRegSel, PCSrc;
   logic [2:0] ALUOp, state;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0] cap_pcsrc, cap_wrsel;
   logic [2:0] cap_aluop;
   logic       cap_regwre, cap_dbsrc, cap_memwr, cap_srca, cap_srcb, cap_ext;

   control_unit #(.OPW(6), .STW(3)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .op        (op),
      .zero      (zero),
      .PCWre     (PCWre),
      .IRWre     (IRWre),
      .RegWre    (RegWre),
      .WrRegSel  (WrRegSel),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .ExtSel    (ExtSel),
      .DataMemWr (DataMemWr),
      .DBDataSrc (DBDataSrc),
      .PCSrc     (PCSrc),
      .state     (state)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Starts in sIF; walks lat cycles, checking state sequence and write-enable totals
   task automatic run_instr(input string tag, input logic [5:0] opc, input logic z,
                            input int lat, input logic [14:0] seq,
                            input int exp_regw, input int exp_memw);
      int pcw = 0;
      int regw = 0;
      int memw = 0;
      int pc_at = -1;
      op   = opc;
      zero = z;
      for (int c = 0; c < lat; c++) begin
         check({tag, "_state"}, 32'(state), 32'(seq[3*c +: 3]));
         if (PCWre) begin
            pcw++;
            pc_at      = c;
            cap_pcsrc  = PCSrc;
            cap_wrsel  = WrRegSel;
            cap_aluop  = ALUOp;
            cap_regwre = RegWre;
            cap_dbsrc  = DBDataSrc;
            cap_memwr  = DataMemWr;
            cap_srca   = ALUSrcA;
            cap_srcb   = ALUSrcB;
            cap_ext    = ExtSel;
         end
         if (RegWre)    regw++;
         if (DataMemWr) memw++;
         tick();
      end
      check({tag, "_pcwre_cnt"}, 32'(pcw), 32'd1);
      check({tag, "_pcwre_at"}, 32'(pc_at), 32'(lat - 1));
      check({tag, "_regwre_cnt"}, 32'(regw), 32'(exp_regw));
      check({tag, "_memwr_cnt"}, 32'(memw), 32'(exp_memw));
      check({tag, "_end_state"}, 32'(state), 32'd0);
      check({tag, "_end_irwre"}, 32'(IRWre), 32'd1);
   endtask

   initial begin
      int stuck;
      RST  = 1'b1;
      op   = 6'b000000;
      zero = 1'b0;
      tick();
      tick();
      check("rst_outs", 32'({PCWre, IRWre, RegWre, WrRegSel, ALUSrcA, ALUSrcB, ALUOp,
                             ExtSel, DataMemWr, DBDataSrc, PCSrc, state}), 32'd0);
      op = 6'b110001;
      #1;
      check("rst_outs_lw", 32'({PCWre, IRWre, RegWre, WrRegSel, ALUSrcA, ALUSrcB, ALUOp,
                                ExtSel, DataMemWr, DBDataSrc, PCSrc, state}), 32'd0);
      RST = 1'b0;
      op  = 6'b000000;
      #1;
      check("post_rst_state", 32'(state), 32'd0);
      check("post_rst_irwre", 32'(IRWre), 32'd1);

      run_instr("add", 6'b000000, 1'b0, 4, {3'b000, 3'b111, 3'b110, 3'b001, 3'b000}, 1, 0);
      check("add_wrsel", 32'(cap_wrsel), 32'd2);
      check("add_regwre", 32'(cap_regwre), 32'd1);
      check("add_aluop", 32'(cap_aluop), 32'd0);

      run_instr("sll", 6'b011000, 1'b0, 4, {3'b000, 3'b111, 3'b110, 3'b001, 3'b000}, 1, 0);
      check("sll_srca", 32'(cap_srca), 32'd1);
      check("sll_aluop", 32'(cap_aluop), 32'd4);

      run_instr("ori", 6'b010010, 1'b0, 4, {3'b000, 3'b111, 3'b110, 3'b001, 3'b000}, 1, 0);
      check("ori_srcb", 32'(cap_srcb), 32'd1);
      check("ori_ext", 32'(cap_ext), 32'd0);
      check("ori_aluop", 32'(cap_aluop), 32'd2);
      check("ori_wrsel", 32'(cap_wrsel), 32'd1);

      run_instr("lw", 6'b110001, 1'b0, 5, {3'b100, 3'b011, 3'b010, 3'b001, 3'b000}, 1, 0);
      check("lw_dbsrc", 32'(cap_dbsrc), 32'd1);
      check("lw_regwre", 32'(cap_regwre), 32'd1);
      check("lw_wrsel", 32'(cap_wrsel), 32'd1);
      check("lw_ext", 32'(cap_ext), 32'd1);

      run_instr("sw", 6'b110000, 1'b0, 4, {3'b000, 3'b011, 3'b010, 3'b001, 3'b000}, 0, 1);
      check("sw_memwr", 32'(cap_memwr), 32'd1);

      run_instr("beq_t", 6'b110100, 1'b1, 3, {3'b000, 3'b000, 3'b101, 3'b001, 3'b000}, 0, 0);
      check("beq_t_pcsrc", 32'(cap_pcsrc), 32'd1);
      run_instr("beq_nt", 6'b110100, 1'b0, 3, {3'b000, 3'b000, 3'b101, 3'b001, 3'b000}, 0, 0);
      check("beq_nt_pcsrc", 32'(cap_pcsrc), 32'd0);

      run_instr("j", 6'b111000, 1'b0, 2, {9'd0, 3'b001, 3'b000}, 0, 0);
      check("j_pcsrc", 32'(cap_pcsrc), 32'd3);

`ifdef CU_JUMP_LINK_EN
      run_instr("jal", 6'b111010, 1'b0, 2, {9'd0, 3'b001, 3'b000}, 1, 0);
      check("jal_pcsrc", 32'(cap_pcsrc), 32'd3);
      check("jal_regwre", 32'(cap_regwre), 32'd1);
      check("jal_wrsel", 32'(cap_wrsel), 32'd0);
      run_instr("jr", 6'b111001, 1'b0, 2, {9'd0, 3'b001, 3'b000}, 0, 0);
      check("jr_pcsrc", 32'(cap_pcsrc), 32'd2);
`else
      run_instr("jal", 6'b111010, 1'b0, 2, {9'd0, 3'b001, 3'b000}, 0, 0);
      check("jal_pcsrc", 32'(cap_pcsrc), 32'd0);
      check("jal_regwre", 32'(cap_regwre), 32'd0);
      run_instr("jr", 6'b111001, 1'b0, 2, {9'd0, 3'b001, 3'b000}, 0, 0);
      check("jr_pcsrc", 32'(cap_pcsrc), 32'd0);
`endif

      run_instr("nop", 6'b000011, 1'b0, 2, {9'd0, 3'b001, 3'b000}, 0, 0);
      check("nop_pcsrc", 32'(cap_pcsrc), 32'd0);

      // Reset while sw sits in sMEM
      op = 6'b110000;
      tick();
      tick();
      tick();
      check("swrst_state", 32'(state), 32'd3);
      check("swrst_memwr_pre", 32'(DataMemWr), 32'd1);
      RST = 1'b1;
      #1;
      check("swrst_memwr", 32'(DataMemWr), 32'd0);
      check("swrst_pcwre", 32'(PCWre), 32'd0);
      tick();
      RST = 1'b0;
      op  = 6'b000000;
      #1;
      check("swrst_after_state", 32'(state), 32'd0);
      check("swrst_after_irwre", 32'(IRWre), 32'd1);
      tick();
      check("swrst_next_id", 32'(state), 32'd1);
      tick();
      tick();
      tick();
      check("swrst_add_done", 32'(state), 32'd0);

      // Halt holds with every enable low until reset
      op = 6'b111111;
      tick();
      check("halt_id_state", 32'(state), 32'd1);
      check("halt_id_pcwre", 32'(PCWre), 32'd0);
      stuck = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (PCWre || RegWre || DataMemWr || IRWre) stuck++;
      end
      check("halt_enables", 32'(stuck), 32'd0);
      check("halt_state", 32'(state), 32'd0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      op  = 6'b000000;
      #1;
      check("halt_rst_irwre", 32'(IRWre), 32'd1);
      tick();
      check("halt_rst_id", 32'(state), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter OPW, default 6, opcode width.
REQ-002 Parameter STW, default 3, state-code width.
REQ-003 CLK  in  1  clock; all state changes on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 op  in  OPW  opcode from instruction register; stable from sID onward.
REQ-006 zero  in  1  ALU zero flag, valid in branch-execute cycle.
REQ-007 PCWre  out  1  PC write enable; PC loads next address on the edge where PCWre=1.
REQ-008 IRWre  out  1  instruction register load.
REQ-009 RegWre  out  1  register file write.
REQ-010 WrRegSel  out  2  destination: 00 r31, 01 rt, 10 rd.
REQ-011 ALUSrcA / ALUSrcB  out  1 each  shamt / sign-or-zero-extended immediate select.
REQ-012 ALUOp  out  3  ALU function code.
REQ-013 ExtSel  out  1  1 = sign extend, 0 = zero extend.
REQ-014 DataMemWr  out  1  data memory write.
REQ-015 DBDataSrc  out  1  1 = write-back from memory, 0 = from ALU.
REQ-016 PCSrc  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump address.
REQ-017 state  out  STW  current state, for debug.

Function
REQ-018 States SHALL be: sIF 000, sID 001, sEXE_AL 110, sWB_AL 111, sEXE_BR 101, sEXE_LS 010, sMEM 011, sWB_LD 100; plus sHALT (encoded 000 with internal halt flag).
REQ-019 Transitions: sIF->sID always; sID->sEXE_AL (R-type, addi, ori, slt, sll), sEXE_BR (beq), sEXE_LS (lw, sw), sIF (j, jr, jal), sHALT (halt); sEXE_AL->sWB_AL->sIF; sEXE_BR->sIF; sEXE_LS->sMEM; sMEM->sWB_LD (lw) or sIF (sw); sWB_LD->sIF.
REQ-020 Instruction latency in cycles: j/jr/jal 2, beq 3, R/I-arith 4, sw 4, lw 5.
REQ-021 PCWre SHALL pulse for exactly one cycle per instruction, in its final state (sID for jumps, sEXE_BR, sWB_AL, sMEM for sw, sWB_LD); 0 in every other state.
REQ-022 IRWre SHALL be 1 only in sIF.
REQ-023 RegWre SHALL be 1 only in sWB_AL, sWB_LD, and sID for jal (WrRegSel=00).
REQ-024 DataMemWr SHALL be 1 only in sMEM for sw.
REQ-025 PCSrc SHALL be 01 in sEXE_BR when zero=1, else 00; 11 for j/jal and 10 for jr in sID.
REQ-026 Outputs SHALL be combinational from registered state and op (Moore-plus-opcode); no output depends on zero except PCSrc.
REQ-027 Unknown opcode SHALL behave as nop: sID->sIF with PCWre=1, PCSrc=00, no writes.
REQ-028 sHALT SHALL hold indefinitely with all write enables 0; only RST exits.

Reset
REQ-029 RST=1 at a rising edge SHALL force sIF, clear halt flag; during RST=1 all outputs SHALL be 0.
REQ-030 RST mid-instruction SHALL abort it with no register, memory or PC write on that edge; first post-reset cycle is sIF.

Configuration
REQ-031 Macro CU_JUMP_LINK_EN: defined -> jal and jr decoded per REQ-019/023/025; undefined -> jal and jr treated as unknown opcodes per REQ-027, WrRegSel code 00 never driven.

Structure
REQ-032 Shared package cpu_pkg SHALL hold opcode constants (add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111), state codes, ALUOp and PCSrc codes.
REQ-033 One sub-module, cu_decode, SHALL map (state, op, zero) to outputs; control_unit holds state register and next-state logic.

Verification
REQ-034 Reset then op=000000 (add): states 000,001,110,111,000; PCWre=1 and RegWre=1 only in 111, WrRegSel=10.
REQ-035 op=110001 (lw): 5 cycles; DBDataSrc=1, RegWre=1 in sWB_LD; PCWre exactly once.
REQ-036 op=110100, zero=1 -> PCSrc=01, PCWre=1 in cycle 3; zero=0 -> PCSrc=00.
REQ-037 op=111010 with CU_JUMP_LINK_EN -> sID: PCSrc=11, RegWre=1, WrRegSel=00; without -> PCSrc=00, RegWre=0.
REQ-038 RST asserted in sMEM for sw -> DataMemWr=0 on that edge, next state sIF.
REQ-039 op=111111 -> PCWre stays 0 for 20 cycles; RST -> sIF.
